tmds_clk_reset_seq: RTL



---
 rtl/tmds_clk_reset_seq_pkg.sv | 26 ++
 rtl/tmds_clk_reset_seq_if.sv | 33 +++
 rtl/tmds_clk_reset_seq_sync_2ff.sv | 24 ++
 rtl/tmds_clk_reset_seq.sv | 116 +++++++++++
 4 files changed

// File: rtl/tmds_clk_reset_seq_pkg.sv
// Shared types and helpers for the TMDS PLL reset sequencer.
// Holds the sequencer state encoding, the event-count width and the counter sizing function.
package tmds_seq_pkg;

  typedef enum logic [2:0] {
    PllRst,
    WaitLock,
    Stable,
    SerRel,
    Run
  } state_e;

  localparam int unsigned CountW = 8;

  // Wide enough to hold (largest cycle parameter - 1); never narrower than 1 bit.
  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b,
                                            input int unsigned c, input int unsigned d);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/tmds_clk_reset_seq_if.sv
// PLL-side and pipeline-side signals of the reset sequencer.
interface tmds_clk_reset_seq_if;
  import tmds_seq_pkg::*;

  logic              pll_lock;
  logic              pll_reset;
  logic              serdes_reset;
  logic              pix_reset;
  logic              ready;
  logic [CountW-1:0] lock_loss_count;
  logic [CountW-1:0] timeout_count;

  modport master (
    input  pll_lock,
    output pll_reset,
    output serdes_reset,
    output pix_reset,
    output ready,
    output lock_loss_count,
    output timeout_count
  );

  modport slave (
    output pll_lock,
    input  pll_reset,
    input  serdes_reset,
    input  pix_reset,
    input  ready,
    input  lock_loss_count,
    input  timeout_count
  );

endinterface

// File: rtl/tmds_clk_reset_seq_sync_2ff.sv
// Single-bit two-flop synchronizer; synchronous reset clears both stages.
module sync_2ff (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/tmds_clk_reset_seq.sv
// Crystal-clocked reset sequencer for the TMDS rPLL: pulses PLL reset, qualifies lock,
// then releases serializer reset followed by pixel-pipeline reset.
module tmds_clk_reset_seq
  import tmds_seq_pkg::*;
#(
  parameter int unsigned PLL_RESET_CYCLES    = 16,
  parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
  parameter int unsigned SERDES_HOLD_CYCLES  = 64,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 2700000
) (
  input  logic                         i_clk,
  input  logic                         i_reset,
  tmds_clk_reset_seq_if.master         io_seq
);

  localparam int unsigned CntW = cnt_width(PLL_RESET_CYCLES, LOCK_STABLE_CYCLES,
                                           SERDES_HOLD_CYCLES, LOCK_TIMEOUT_CYCLES);

  if (PLL_RESET_CYCLES < 1 || LOCK_STABLE_CYCLES < 1 || SERDES_HOLD_CYCLES < 1 ||
      LOCK_TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("tmds_clk_reset_seq: every cycle parameter must be at least 1");
  end

  localparam logic [CntW-1:0] PllLast     = CntW'(PLL_RESET_CYCLES - 1);
  localparam logic [CntW-1:0] StableLast  = CntW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CntW-1:0] HoldLast    = CntW'(SERDES_HOLD_CYCLES - 1);
  localparam logic [CntW-1:0] TimeoutLast = CntW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CountW-1:0] CountMax  = '1;

  state_e            r_state, w_state_d;
  logic [CntW-1:0]   r_cnt, w_cnt_d;
  logic [CountW-1:0] r_loss, w_loss_d;
  logic [CountW-1:0] r_timeout, w_timeout_d;
  logic              r_pll_reset, r_serdes_reset, r_pix_reset, r_ready;
  logic              w_lock_s;

  sync_2ff u_lock_sync (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_d     (io_seq.pll_lock),
    .o_q     (w_lock_s)
  );

  always_comb begin
    w_state_d   = r_state;
    w_cnt_d     = r_cnt + 1'b1;
    w_loss_d    = r_loss;
    w_timeout_d = r_timeout;
    unique case (r_state)
      PllRst: begin
        if (r_cnt == PllLast) w_state_d = WaitLock;
      end
      WaitLock: begin
        // Lock seen on the timeout cycle takes priority over the timeout.
        if (w_lock_s) begin
          w_state_d = Stable;
        end else if (r_cnt == TimeoutLast) begin
          w_state_d   = PllRst;
          w_timeout_d = (r_timeout == CountMax) ? r_timeout : r_timeout + 1'b1;
        end
      end
      Stable: begin
        if (!w_lock_s) w_state_d = WaitLock;
        else if (r_cnt == StableLast) w_state_d = SerRel;
      end
      SerRel: begin
        if (!w_lock_s) begin
          w_state_d = WaitLock;
          w_loss_d  = (r_loss == CountMax) ? r_loss : r_loss + 1'b1;
        end else if (r_cnt == HoldLast) begin
          w_state_d = Run;
        end
      end
      Run: begin
        if (!w_lock_s) begin
          w_state_d = WaitLock;
          w_loss_d  = (r_loss == CountMax) ? r_loss : r_loss + 1'b1;
        end
      end
      default: w_state_d = PllRst;
    endcase
    if (w_state_d != r_state) w_cnt_d = '0;
  end

  // Outputs are decoded from the next state so they register alongside it.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state        <= PllRst;
      r_cnt          <= '0;
      r_loss         <= '0;
      r_timeout      <= '0;
      r_pll_reset    <= 1'b1;
      r_serdes_reset <= 1'b1;
      r_pix_reset    <= 1'b1;
      r_ready        <= 1'b0;
    end else begin
      r_state        <= w_state_d;
      r_cnt          <= w_cnt_d;
      r_loss         <= w_loss_d;
      r_timeout      <= w_timeout_d;
      r_pll_reset    <= (w_state_d == PllRst);
      r_serdes_reset <= (w_state_d == PllRst) || (w_state_d == WaitLock) ||
                        (w_state_d == Stable);
      r_pix_reset    <= (w_state_d != Run);
      r_ready        <= (w_state_d == Run);
    end
  end

  assign io_seq.pll_reset       = r_pll_reset;
  assign io_seq.serdes_reset    = r_serdes_reset;
  assign io_seq.pix_reset       = r_pix_reset;
  assign io_seq.ready           = r_ready;
  assign io_seq.lock_loss_count = r_loss;
  assign io_seq.timeout_count   = r_timeout;

endmodule
